// File: rtl/vga_raster_timing.sv
// vga_raster_timing
//   Raster timing source and pixel sink for a 640x480@60 display path. A phase counter divides
//   clk_50MHz down to the pixel-slot rate, and horizontal and vertical slot counters scan the
//   frame. The current coordinates and blanking go to the renderer. The renderer's COLOR is
//   sampled back at the end of each slot, then shifted out on RGB. Sync and blank are pipelined
//   the same way, so all three stay mutually aligned.
//
// Ports
//   clk_50MHz    in   system clock, all state on the rising edge
//   RESET        in   synchronous active-high reset
//   COLOR[7:0]   in   renderer pixel {R[2:0],G[2:0],B[1:0]}
//   CLK_DATA     out  pixel-rate clock to the renderer, high for the first half of each slot
//   CURX[9:0]    out  horizontal slot counter
//   CURY[8:0]    out  active line, 0 while VBLANK
//   HBLANK       out  horizontal blanking of the current slot
//   VBLANK       out  vertical blanking of the current line
//   FRAME_START  out  single-cycle pulse on the first cycle of slot (0,0)
//   hs_vga       out  horizontal sync, delayed to match RGB
//   vs_vga       out  vertical sync, delayed to match RGB
//   RED/GREEN/BLUE out  pixel drive, 0 while the delayed blank is set
module vga_raster_timing #(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter int unsigned COLOR_LAT = 1,
    parameter bit          SYNC_POL  = 1'b0
) (
    input  logic       clk_50MHz,
    input  logic       RESET,
    input  logic [7:0] COLOR,
    output logic       CLK_DATA,
    output logic [9:0] CURX,
    output logic [8:0] CURY,
    output logic       HBLANK,
    output logic       VBLANK,
    output logic       FRAME_START,
    output logic       hs_vga,
    output logic       vs_vga,
    output logic [2:0] RED,
    output logic [2:0] GREEN,
    output logic [1:0] BLUE
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned PW      = $clog2(CLK_DIV);

    localparam logic [PW-1:0] PhaseLast = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PhaseHalf = PW'(CLK_DIV / 2);
    localparam logic [9:0]    HLast     = 10'(H_TOTAL - 1);
    localparam logic [9:0]    VLast     = 10'(V_TOTAL - 1);
    localparam logic [9:0]    HActive   = 10'(H_ACTIVE);
    localparam logic [9:0]    VActive   = 10'(V_ACTIVE);
    localparam logic [9:0]    HsStart   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]    HsEnd     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]    VsStart   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]    VsEnd     = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [PW-1:0] phaseQ, phaseD;
    logic [9:0]    hcntQ, hcntD;
    logic [9:0]    vcntQ, vcntD;
    logic [8:0]    curyQ, curyD;
    logic          hblankQ, vblankQ;
    logic          frameStartQ;
    logic          firstQ;
    logic          pixCe;
    logic          rawHs, rawVs, rawBlank;

    // Pipe stage i holds the value from i+1 slots ago; stage COLOR_LAT-1 drives the pins.
    logic [COLOR_LAT-1:0] hsPipeQ;
    logic [COLOR_LAT-1:0] vsPipeQ;
    logic [COLOR_LAT-1:0] blankPipeQ;
    logic [7:0]           colorPipeQ [COLOR_LAT];

    assign pixCe = (phaseQ == PhaseLast);

    always_comb begin
        phaseD = pixCe ? '0 : phaseQ + PW'(1);
        hcntD  = hcntQ;
        vcntD  = vcntQ;
        if (pixCe) begin
            if (hcntQ == HLast) begin
                hcntD = '0;
                vcntD = (vcntQ == VLast) ? '0 : vcntQ + 10'd1;
            end else begin
                hcntD = hcntQ + 10'd1;
            end
        end
        curyD = (vcntD < VActive) ? vcntD[8:0] : '0;
    end

    // Raw sync/blank belong to the slot currently being presented on CURX/CURY.
    assign rawHs    = (hcntQ >= HsStart) && (hcntQ < HsEnd);
    assign rawVs    = (vcntQ >= VsStart) && (vcntQ < VsEnd);
    assign rawBlank = hblankQ | vblankQ;

    always_ff @(posedge clk_50MHz) begin
        if (RESET) begin
            phaseQ      <= '0;
            hcntQ       <= '0;
            vcntQ       <= '0;
            curyQ       <= '0;
            hblankQ     <= 1'b0;
            vblankQ     <= 1'b0;
            frameStartQ <= 1'b0;
            firstQ      <= 1'b1;
            for (int i = 0; i < COLOR_LAT; i++) begin
                hsPipeQ[i]    <= 1'b0;
                vsPipeQ[i]    <= 1'b0;
                blankPipeQ[i] <= 1'b1;
                colorPipeQ[i] <= '0;
            end
        end else begin
            phaseQ  <= phaseD;
            hcntQ   <= hcntD;
            vcntQ   <= vcntD;
            curyQ   <= curyD;
            hblankQ <= (hcntD >= HActive);
            vblankQ <= (vcntD >= VActive);
            // The reset cycles must read 0, so the post-reset frame pulse lands on the first
            // cycle out of reset; later pulses mark the wrap into slot (0,0).
            frameStartQ <= firstQ | (pixCe && (hcntD == '0) && (vcntD == '0));
            firstQ      <= 1'b0;
            if (pixCe) begin
                hsPipeQ[0]    <= rawHs;
                vsPipeQ[0]    <= rawVs;
                blankPipeQ[0] <= rawBlank;
                colorPipeQ[0] <= COLOR;
                for (int i = 1; i < COLOR_LAT; i++) begin
                    hsPipeQ[i]    <= hsPipeQ[i-1];
                    vsPipeQ[i]    <= vsPipeQ[i-1];
                    blankPipeQ[i] <= blankPipeQ[i-1];
                    colorPipeQ[i] <= colorPipeQ[i-1];
                end
            end
        end
    end

    assign CLK_DATA    = (phaseQ < PhaseHalf);
    assign CURX        = hcntQ;
    assign CURY        = curyQ;
    assign HBLANK      = hblankQ;
    assign VBLANK      = vblankQ;
    assign FRAME_START = frameStartQ;
    assign hs_vga      = hsPipeQ[COLOR_LAT-1] ? SYNC_POL : ~SYNC_POL;
    assign vs_vga      = vsPipeQ[COLOR_LAT-1] ? SYNC_POL : ~SYNC_POL;
    assign {RED, GREEN, BLUE} = blankPipeQ[COLOR_LAT-1] ? 8'h00 : colorPipeQ[COLOR_LAT-1];

endmodule
